// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep controller and its phase accumulator.
package dds_pkg;

  localparam int DDS_PHASE_W = 24;
  localparam int DDS_ADDR_W  = 8;
  localparam int DDS_DWELL_W = 16;

  typedef enum logic [1:0] {
    FIXED  = 2'b00,
    SINGLE = 2'b01,
    SAW    = 2'b10,
    UPDOWN = 2'b11
  } dds_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIXED,
    ST_SWEEP_UP,
    ST_SWEEP_DOWN,
    ST_HOLD
  } dds_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Config handshake, start/stop pulses and address/status outputs of the DDS sweep controller.
// DDS_PHASE_OFFSET_EN adds the cfg_poff_i address offset field.
interface dds_sweep_ctrl_if import dds_pkg::*; #(
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int ADDR_W  = DDS_ADDR_W,
  parameter int DWELL_W = DDS_DWELL_W
);
  logic               cfg_valid_i;
  logic               cfg_ready_o;
  logic [1:0]         cfg_mode_i;
  logic [PHASE_W-1:0] cfg_ftw_start_i;
  logic [PHASE_W-1:0] cfg_ftw_stop_i;
  logic [PHASE_W-1:0] cfg_ftw_step_i;
  logic [DWELL_W-1:0] cfg_dwell_i;
`ifdef DDS_PHASE_OFFSET_EN
  logic [ADDR_W-1:0]  cfg_poff_i;
`endif
  logic               start_i;
  logic               stop_i;
  logic [ADDR_W-1:0]  addr_o;
  logic               addr_valid_o;
  logic [PHASE_W-1:0] cur_ftw_o;
  logic               busy_o;
  logic               sweep_done_o;

  modport master (
`ifdef DDS_PHASE_OFFSET_EN
    output cfg_poff_i,
`endif
    output cfg_valid_i, cfg_mode_i, cfg_ftw_start_i, cfg_ftw_stop_i, cfg_ftw_step_i,
    output cfg_dwell_i, start_i, stop_i,
    input  cfg_ready_o, addr_o, addr_valid_o, cur_ftw_o, busy_o, sweep_done_o
  );

  modport slave (
`ifdef DDS_PHASE_OFFSET_EN
    input  cfg_poff_i,
`endif
    input  cfg_valid_i, cfg_mode_i, cfg_ftw_start_i, cfg_ftw_stop_i, cfg_ftw_step_i,
    input  cfg_dwell_i, start_i, stop_i,
    output cfg_ready_o, addr_o, addr_valid_o, cur_ftw_o, busy_o, sweep_done_o
  );

endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator: adds the tuning word every enabled cycle and slices the LUT address from the top bits.
// DDS_PHASE_OFFSET_EN adds a per-config address offset on the register output (no extra latency).
module dds_phase_acc #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [PHASE_W-1:0] ftw,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [ADDR_W-1:0]  poff,
`endif
  output logic [ADDR_W-1:0]  addr
);

  logic [PHASE_W-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + ftw;
    end
  end

`ifdef DDS_PHASE_OFFSET_EN
  // Offset is gated so an idle controller still presents address 0.
  assign addr = phase[PHASE_W-1 -: ADDR_W] + (en ? poff : '0);
`else
  assign addr = phase[PHASE_W-1 -: ADDR_W];
`endif

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sequencing controller: config registers, sweep FSM, dwell counter and step arithmetic.
// DDS_PHASE_OFFSET_EN enables the latched LUT address offset.
module dds_sweep_ctrl import dds_pkg::*; #(
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int ADDR_W  = DDS_ADDR_W,
  parameter int DWELL_W = DDS_DWELL_W
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  dds_sweep_ctrl_if.slave bus
);

  dds_state_t         state, state_nxt;
  dds_mode_t          mode_q, eff_mode;
  logic [PHASE_W-1:0] start_q, stop_q, step_q;
  logic [PHASE_W-1:0] eff_start, eff_stop, eff_step;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt, dwell_cnt_nxt;
  logic [PHASE_W-1:0] cur_ftw, cur_ftw_nxt;
  logic               done, done_nxt;
  logic [PHASE_W:0]   up_sum, dn_diff;
  logic               idle, cfg_take, degenerate, dwell_hit;
`ifdef DDS_PHASE_OFFSET_EN
  logic [ADDR_W-1:0]  poff_q;
`endif

  assign idle     = (state == ST_IDLE);
  assign cfg_take = bus.cfg_valid_i & idle;

  // A start coinciding with a config beat must see the new values, not the old registers.
  assign eff_mode  = cfg_take ? dds_mode_t'(bus.cfg_mode_i) : mode_q;
  assign eff_start = cfg_take ? bus.cfg_ftw_start_i : start_q;
  assign eff_stop  = cfg_take ? bus.cfg_ftw_stop_i  : stop_q;
  assign eff_step  = cfg_take ? bus.cfg_ftw_step_i  : step_q;
  assign degenerate = (eff_step == '0) | (eff_stop <= eff_start);

  assign up_sum    = {1'b0, cur_ftw} + {1'b0, step_q};
  assign dn_diff   = {1'b0, cur_ftw} - {1'b0, step_q};
  assign dwell_hit = (dwell_cnt == dwell_q);

  always_comb begin
    state_nxt     = state;
    cur_ftw_nxt   = cur_ftw;
    dwell_cnt_nxt = dwell_cnt;
    done_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i && !bus.stop_i) begin
          cur_ftw_nxt   = eff_start;
          dwell_cnt_nxt = '0;
          state_nxt     = (eff_mode == FIXED || degenerate) ? ST_FIXED : ST_SWEEP_UP;
        end
      end
      ST_SWEEP_UP: begin
        if (dwell_hit) begin
          dwell_cnt_nxt = '0;
          if (up_sum < {1'b0, stop_q}) begin
            cur_ftw_nxt = up_sum[PHASE_W-1:0];
          end else begin
            case (mode_q)
              SINGLE: begin
                cur_ftw_nxt = stop_q;
                done_nxt    = 1'b1;
                state_nxt   = ST_HOLD;
              end
              SAW: begin
                cur_ftw_nxt = start_q;
                done_nxt    = 1'b1;
              end
              default: begin
                cur_ftw_nxt = stop_q;
                state_nxt   = ST_SWEEP_DOWN;
              end
            endcase
          end
        end else begin
          dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
        end
      end
      ST_SWEEP_DOWN: begin
        if (dwell_hit) begin
          dwell_cnt_nxt = '0;
          if (!dn_diff[PHASE_W] && (dn_diff[PHASE_W-1:0] > start_q)) begin
            cur_ftw_nxt = dn_diff[PHASE_W-1:0];
          end else begin
            cur_ftw_nxt = start_q;
            done_nxt    = 1'b1;
            state_nxt   = ST_SWEEP_UP;
          end
        end else begin
          dwell_cnt_nxt = dwell_cnt + DWELL_W'(1);
        end
      end
      default: ;
    endcase
    // Stop overrides everything, including an endpoint landing in the same cycle.
    if (bus.stop_i && !idle) begin
      state_nxt     = ST_IDLE;
      cur_ftw_nxt   = '0;
      dwell_cnt_nxt = '0;
      done_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      cur_ftw   <= '0;
      dwell_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_ftw   <= cur_ftw_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      done      <= done_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q  <= FIXED;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
`ifdef DDS_PHASE_OFFSET_EN
      poff_q  <= '0;
`endif
    end else if (cfg_take) begin
      mode_q  <= dds_mode_t'(bus.cfg_mode_i);
      start_q <= bus.cfg_ftw_start_i;
      stop_q  <= bus.cfg_ftw_stop_i;
      step_q  <= bus.cfg_ftw_step_i;
      dwell_q <= bus.cfg_dwell_i;
`ifdef DDS_PHASE_OFFSET_EN
      poff_q  <= bus.cfg_poff_i;
`endif
    end
  end

  dds_phase_acc #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W)
  ) u_phase_acc (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (idle | bus.stop_i),
    .en    (!idle),
    .ftw   (cur_ftw),
`ifdef DDS_PHASE_OFFSET_EN
    .poff  (poff_q),
`endif
    .addr  (bus.addr_o)
  );

  assign bus.cfg_ready_o  = idle;
  assign bus.busy_o       = !idle;
  assign bus.addr_valid_o = !idle;
  assign bus.cur_ftw_o    = cur_ftw;
  assign bus.sweep_done_o = done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected tuning words / addresses are queued at start and drained per cycle.
module tb_dds_sweep_ctrl;

  localparam int PW = 24;
  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic [PW-1:0] ftw;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [AW-1:0] asb[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.PHASE_W(PW), .ADDR_W(AW), .DWELL_W(DW)) bus ();

  dds_sweep_ctrl #(.PHASE_W(PW), .ADDR_W(AW), .DWELL_W(DW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cfg_valid_i     = 1'b0;
    bus.cfg_mode_i      = 2'b00;
    bus.cfg_ftw_start_i = '0;
    bus.cfg_ftw_stop_i  = '0;
    bus.cfg_ftw_step_i  = '0;
    bus.cfg_dwell_i     = '0;
`ifdef DDS_PHASE_OFFSET_EN
    bus.cfg_poff_i      = '0;
`endif
    bus.start_i         = 1'b0;
    bus.stop_i          = 1'b0;
  endtask

  task automatic drive_cfg(input logic [1:0] m, input logic [PW-1:0] s, input logic [PW-1:0] e,
                           input logic [PW-1:0] st, input logic [DW-1:0] d);
    bus.cfg_valid_i     = 1'b1;
    bus.cfg_mode_i      = m;
    bus.cfg_ftw_start_i = s;
    bus.cfg_ftw_stop_i  = e;
    bus.cfg_ftw_step_i  = st;
    bus.cfg_dwell_i     = d;
  endtask

  task automatic push_level(input logic [PW-1:0] f, input int n, input logic d);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.ftw  = f;
      e.done = (i == 0) ? d : 1'b0;
      sb.push_back(e);
    end
  endtask

  // Issue a start (optionally with a config beat) and leave the bench one cycle after the start edge.
  task automatic do_start(input logic with_cfg);
    bus.cfg_valid_i = with_cfg;
    bus.start_i     = 1'b1;
    tick();
    bus.cfg_valid_i = 1'b0;
    bus.start_i     = 1'b0;
  endtask

  task automatic do_stop;
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.cfg_ready_o !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.addr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_addr_valid: got %b expected 0", bus.addr_valid_o); end
    checks++; if (bus.addr_o !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 00", bus.addr_o); end
    checks++; if (bus.cur_ftw_o !== '0) begin errors++; $display("FAIL reset_cur_ftw: got %h expected 000000", bus.cur_ftw_o); end
    checks++; if (bus.sweep_done_o !== 1'b0) begin errors++; $display("FAIL reset_sweep_done: got %b expected 0", bus.sweep_done_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed;
    drive_cfg(2'b00, 24'h010000, 24'h0, 24'h0, 16'd0);
    for (int i = 0; i <= 256; i++) asb.push_back(AW'(i));
    do_start(1'b1);
    while (asb.size() > 0) begin
      logic [AW-1:0] a;
      a = asb.pop_front();
      checks++; if (bus.addr_o !== a) begin errors++; $display("FAIL fixed_addr: got %h expected %h", bus.addr_o, a); end
      checks++; if (bus.addr_valid_o !== 1'b1) begin errors++; $display("FAIL fixed_addr_valid: got %b expected 1", bus.addr_valid_o); end
      checks++; if (bus.sweep_done_o !== 1'b0) begin errors++; $display("FAIL fixed_no_done: got %b expected 0", bus.sweep_done_o); end
      checks++; if (bus.cur_ftw_o !== 24'h010000) begin errors++; $display("FAIL fixed_cur_ftw: got %h expected 010000", bus.cur_ftw_o); end
      tick();
    end
    do_stop();
  endtask

  task automatic test_single;
    drive_cfg(2'b01, 24'h010000, 24'h040000, 24'h010000, 16'd3);
    push_level(24'h010000, 4, 1'b0);
    push_level(24'h020000, 4, 1'b0);
    push_level(24'h030000, 4, 1'b0);
    push_level(24'h040000, 10, 1'b1);
    do_start(1'b1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; if (bus.cur_ftw_o !== e.ftw) begin errors++; $display("FAIL single_cur_ftw: got %h expected %h", bus.cur_ftw_o, e.ftw); end
      checks++; if (bus.sweep_done_o !== e.done) begin errors++; $display("FAIL single_done: got %b expected %b", bus.sweep_done_o, e.done); end
      tick();
    end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL single_hold_busy: got %b expected 1", bus.busy_o); end
    do_stop();
  endtask

  task automatic test_updown;
    drive_cfg(2'b11, 24'h100, 24'h350, 24'h100, 16'd0);
    for (int r = 0; r < 2; r++) begin
      push_level(24'h100, 1, r != 0);
      push_level(24'h200, 1, 1'b0);
      push_level(24'h300, 1, 1'b0);
      push_level(24'h350, 1, 1'b0);
      push_level(24'h250, 1, 1'b0);
      push_level(24'h150, 1, 1'b0);
    end
    push_level(24'h100, 1, 1'b1);
    push_level(24'h200, 1, 1'b0);
    do_start(1'b1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; if (bus.cur_ftw_o !== e.ftw) begin errors++; $display("FAIL updown_cur_ftw: got %h expected %h", bus.cur_ftw_o, e.ftw); end
      checks++; if (bus.sweep_done_o !== e.done) begin errors++; $display("FAIL updown_done: got %b expected %b", bus.sweep_done_o, e.done); end
      tick();
    end
    do_stop();
  endtask

  task automatic test_saw;
    drive_cfg(2'b10, 24'h100, 24'h350, 24'h100, 16'd0);
    for (int r = 0; r < 3; r++) begin
      push_level(24'h100, 1, r != 0);
      push_level(24'h200, 1, 1'b0);
      push_level(24'h300, 1, 1'b0);
    end
    do_start(1'b1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; if (bus.cur_ftw_o !== e.ftw) begin errors++; $display("FAIL saw_cur_ftw: got %h expected %h", bus.cur_ftw_o, e.ftw); end
      checks++; if (bus.sweep_done_o !== e.done) begin errors++; $display("FAIL saw_done: got %b expected %b", bus.sweep_done_o, e.done); end
      tick();
    end
    do_stop();
  endtask

  task automatic test_stop_cfg_lock;
    drive_cfg(2'b01, 24'h010000, 24'h040000, 24'h010000, 16'd3);
    push_level(24'h010000, 4, 1'b0);
    push_level(24'h020000, 1, 1'b0);
    do_start(1'b1);
    checks++; if (bus.cfg_ready_o !== 1'b0) begin errors++; $display("FAIL busy_cfg_ready: got %b expected 0", bus.cfg_ready_o); end
    // Present a different config throughout the run; it must be ignored.
    drive_cfg(2'b00, 24'h000777, 24'h0, 24'h0, 16'd0);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; if (bus.cur_ftw_o !== e.ftw) begin errors++; $display("FAIL lock_cur_ftw: got %h expected %h", bus.cur_ftw_o, e.ftw); end
      tick();
    end
    bus.cfg_valid_i = 1'b0;
    do_stop();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.addr_valid_o !== 1'b0) begin errors++; $display("FAIL stop_addr_valid: got %b expected 0", bus.addr_valid_o); end
    checks++; if (bus.addr_o !== '0) begin errors++; $display("FAIL stop_addr: got %h expected 00", bus.addr_o); end
    checks++; if (bus.cfg_ready_o !== 1'b1) begin errors++; $display("FAIL stop_cfg_ready: got %b expected 1", bus.cfg_ready_o); end
    checks++; if (bus.cur_ftw_o !== '0) begin errors++; $display("FAIL stop_cur_ftw: got %h expected 000000", bus.cur_ftw_o); end
    checks++; if (bus.sweep_done_o !== 1'b0) begin errors++; $display("FAIL stop_done: got %b expected 0", bus.sweep_done_o); end
    push_level(24'h010000, 4, 1'b0);
    push_level(24'h020000, 2, 1'b0);
    do_start(1'b0);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; if (bus.cur_ftw_o !== e.ftw) begin errors++; $display("FAIL restart_cur_ftw: got %h expected %h", bus.cur_ftw_o, e.ftw); end
      tick();
    end
    do_stop();
    idle_inputs();
  endtask

  task automatic test_async_reset;
    drive_cfg(2'b11, 24'h100, 24'h350, 24'h100, 16'd0);
    do_start(1'b1);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.addr_valid_o !== 1'b0) begin errors++; $display("FAIL arst_addr_valid: got %b expected 0", bus.addr_valid_o); end
    checks++; if (bus.addr_o !== '0) begin errors++; $display("FAIL arst_addr: got %h expected 00", bus.addr_o); end
    checks++; if (bus.cur_ftw_o !== '0) begin errors++; $display("FAIL arst_cur_ftw: got %h expected 000000", bus.cur_ftw_o); end
    checks++; if (bus.sweep_done_o !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", bus.sweep_done_o); end
    checks++; if (bus.cfg_ready_o !== 1'b1) begin errors++; $display("FAIL arst_cfg_ready: got %b expected 1", bus.cfg_ready_o); end
    #2;
    rst_n = 1'b1;
    tick();
    drive_cfg(2'b10, 24'h200, 24'h500, 24'h100, 16'd1);
    push_level(24'h200, 2, 1'b0);
    push_level(24'h300, 2, 1'b0);
    push_level(24'h400, 2, 1'b0);
    push_level(24'h200, 2, 1'b1);
    push_level(24'h300, 1, 1'b0);
    do_start(1'b1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++; if (bus.cur_ftw_o !== e.ftw) begin errors++; $display("FAIL newcfg_cur_ftw: got %h expected %h", bus.cur_ftw_o, e.ftw); end
      checks++; if (bus.sweep_done_o !== e.done) begin errors++; $display("FAIL newcfg_done: got %b expected %b", bus.sweep_done_o, e.done); end
      tick();
    end
    do_stop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed();
    test_single();
    test_updown();
    test_saw();
    test_stop_cfg_lock();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencing controller for the DDS waveform path. Owns the phase accumulator and generates the 8-bit address stream consumed by the waveform lookup tables (triangle, sine, square). It runs a fixed frequency or a programmed frequency sweep: linear up, sawtooth repeat, or up/down ping-pong. It is configured over a valid/ready handshake and started and stopped by pulses.

Parameters:
PHASE_W, 24, phase accumulator and tuning-word width.
ADDR_W, 8, LUT address width; the top ADDR_W bits of the phase.
DWELL_W, 16, dwell counter width.

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
cfg_valid_i  in  1  config presented
cfg_ready_o  out  1  config accepted; high exactly when state==IDLE
cfg_mode_i  in  2  00 fixed, 01 single sweep, 10 sawtooth repeat, 11 up/down
cfg_ftw_start_i  in  PHASE_W  start tuning word
cfg_ftw_stop_i  in  PHASE_W  stop tuning word
cfg_ftw_step_i  in  PHASE_W  per-step increment
cfg_dwell_i  in  DWELL_W  cycles per step, minus 1
start_i  in  1  start pulse
stop_i  in  1  stop pulse
addr_o  out  ADDR_W  LUT address
addr_valid_o  out  1  addr_o meaningful
cur_ftw_o  out  PHASE_W  tuning word currently applied
busy_o  out  1  state != IDLE
sweep_done_o  out  1  one-cycle pulse at each sweep endpoint

Behaviour:
- Reset (async assert, sync release): state IDLE; phase, cur_ftw and dwell counter 0; config registers 0; addr_o=0, addr_valid_o=0, busy_o=0, sweep_done_o=0, cur_ftw_o=0, cfg_ready_o=1.
- States: IDLE, FIXED, SWEEP_UP, SWEEP_DOWN, HOLD.
- Config:
  - Latched on cfg_valid_i & cfg_ready_o.
  - Ignored outside IDLE.
  - cfg_valid_i and start_i in the same IDLE cycle: the start uses the newly presented config.
- Start (IDLE & start_i & !stop_i):
  - Next cycle: phase=0, cur_ftw=ftw_start, dwell counter=0, addr_valid_o=1.
  - Next state: FIXED if mode 00; otherwise SWEEP_UP.
  - Degenerate config (mode!=00 and (step==0 or stop<=start)) runs as FIXED.
- Phase accumulation:
  - In every non-IDLE cycle, phase <= phase + cur_ftw, modulo 2^PHASE_W.
  - addr_o = phase[PHASE_W-1 -: ADDR_W], driven from the register; zero extra latency.
- Dwell timing:
  - Dwell counter counts 0..dwell in SWEEP_UP and SWEEP_DOWN.
  - cur_ftw updates on the cycle the counter equals dwell, then the counter clears.
  - Each frequency is therefore applied for dwell+1 cycles.
- SWEEP_UP step: next = cur_ftw + step, computed at PHASE_W+1 bits with no wrap.
  - next < stop: cur_ftw=next.
  - Otherwise cur_ftw=stop (clamp), then by mode:
    - 01: pulse sweep_done_o, go to HOLD.
    - 10: pulse sweep_done_o, cur_ftw=start instead of stop, stay in SWEEP_UP.
    - 11: go to SWEEP_DOWN, no pulse.
- SWEEP_DOWN step: next = cur_ftw - step.
  - next > start with no borrow: cur_ftw=next.
  - Otherwise cur_ftw=start, pulse sweep_done_o, go to SWEEP_UP.
- HOLD: accumulate at ftw_stop indefinitely.
- Stop:
  - stop_i in any non-IDLE state: next cycle IDLE, phase=0, cur_ftw=0, addr_valid_o=0, no sweep_done_o pulse.
  - stop_i wins over start_i in IDLE and over a simultaneous endpoint.
- sweep_done_o is registered and aligned with the cycle the new cur_ftw_o appears.

Optional Feature:
DDS_PHASE_OFFSET_EN
- Defined:
  - Adds input cfg_poff_i [ADDR_W-1:0], latched with the config.
  - addr_o = phase top bits + poff, modulo 2^ADDR_W; same latency.
  - Offset reset value 0.
- Undefined: no such port; addr_o = phase top bits.

Decomposition:
- Package dds_pkg holds:
  - typedef dds_mode_t (FIXED, SINGLE, SAW, UPDOWN);
  - typedef dds_state_t;
  - default widths DDS_PHASE_W=24, DDS_ADDR_W=8.
- Sub-module dds_phase_acc: accumulator register, clear, enable, ftw input, address slice, optional offset add.
- dds_sweep_ctrl keeps the FSM, config registers, dwell counter and step arithmetic.

Test Plan:
1. Mode 00, ftw_start=0x010000, start -> addr_o 0,1,2,...,255,0; wraps after 256 cycles; addr_valid_o steady 1; sweep_done_o never pulses.
2. Mode 01, start=0x010000, stop=0x040000, step=0x010000, dwell=3 -> cur_ftw_o 0x010000, 0x020000, 0x030000, 0x040000, each held 4 cycles; single sweep_done_o pulse at 0x040000; HOLD, stays 0x040000.
3. Mode 11, start=0x100, stop=0x350, step=0x100, dwell=0 -> cur_ftw_o sequence 0x100, 0x200, 0x300, 0x350, 0x250, 0x150, 0x100, 0x200; sweep_done_o pulses only on the cycle 0x100 is reapplied after the down sweep.
4. Mode 10, same values as 3 -> 0x100, 0x200, 0x300, 0x100 (sweep_done_o pulse), 0x200, ...
5. stop_i mid SWEEP_UP -> next cycle busy_o=0, addr_valid_o=0, addr_o=0, cfg_ready_o=1; cfg_valid_i pulsed while busy leaves the config unchanged (verified after restart).
6. rst_n_i low mid-sweep, asynchronous to the clock -> all outputs reach reset values before the next edge; after release, start_i with cfg_valid_i in the same cycle uses the new config.
